// File: rtl/poly_sub_stream_if.sv
// Purpose : coefficient-pair input and result output bundle for poly_sub_stream.
// Ports   : in_valid_i/in_ready_o/op1_i/op2_i carry operand pairs into the block;
//           out_valid_o/out_ready_i/result_o/idx_o/last_o carry tagged results out.
// Naming  : signal suffixes are from the block's point of view (slave modport).
interface poly_sub_stream_if #(
    parameter int NUM_COEFFS = 256,
    parameter int IDX_W      = $clog2(NUM_COEFFS)
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [11:0]      op1_i;
    logic [11:0]      op2_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [11:0]      result_o;
    logic [IDX_W-1:0] idx_o;
    logic             last_o;

    // The subtraction block.
    modport slave (
        input  in_valid_i, op1_i, op2_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, idx_o, last_o
    );

    // The producer/consumer side (memory ports, write-back, bench).
    modport master (
        output in_valid_i, op1_i, op2_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, idx_o, last_o
    );
endinterface

// File: rtl/poly_sub_stream.sv
// Purpose     : streaming c = a - b mod 3329 over one NUM_COEFFS-coefficient polynomial frame.
// Latency     : one cycle from input accept to registered result; one pair per cycle sustained.
// Backpressure: in_ready_o drops combinationally while a held result is not taken.
// Ports: clk, rst (async active-high); start_i starts a frame in IDLE; busy_o high in RUN/DRAIN;
//        done_o one-cycle pulse after the last result handshake; range_err_o sticky per frame
//        when an accepted operand is >= Q; s_if carries the operand and result streams.
module poly_sub_stream #(
    parameter int NUM_COEFFS = 256,
    parameter int IDX_W      = $clog2(NUM_COEFFS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                range_err_o,
    poly_sub_stream_if.slave    s_if
);
    localparam int               Q        = 3329;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // a - b mod Q for a, b in [0, Q-1]: a borrow out of the 13-bit difference means
    // the true result is negative, so one addition of Q brings it into range.
    function automatic logic [11:0] mod_sub(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[12]) begin
            diff = diff + 13'(Q);
        end
        return diff[11:0];
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [11:0]      result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             range_err_q, range_err_d;

    logic in_ready;
    logic accept;
    logic out_hs;
    logic in_range;

    // A slot opens either when the output register is empty or is being drained this cycle.
    assign in_ready = (state_q == RUN) && (!out_valid_q || s_if.out_ready_i);
    assign accept   = s_if.in_valid_i && in_ready;
    assign out_hs   = out_valid_q && s_if.out_ready_i;
    assign in_range = (s_if.op1_i < 12'(Q)) && (s_if.op2_i < 12'(Q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        idx_d       = idx_q;
        last_d      = last_q;
        range_err_d = range_err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    range_err_d = 1'b0;
                end
            end
            RUN: begin
                if (accept && (cnt_q == LAST_IDX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept wins over a plain handshake: a simultaneous take-and-load keeps valid high.
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = in_range ? mod_sub(s_if.op1_i, s_if.op2_i) : 12'd0;
            idx_d       = cnt_q;
            last_d      = (cnt_q == LAST_IDX);
            cnt_d       = cnt_q + 1'b1;   // wraps to 0 after LAST_IDX (power-of-two frame)
            if (!in_range) begin
                range_err_d = 1'b1;
            end
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            range_err_q <= range_err_d;
        end
    end

    assign s_if.in_ready_o  = in_ready;
    assign s_if.out_valid_o = out_valid_q;
    assign s_if.result_o    = result_q;
    assign s_if.idx_o       = idx_q;
    assign s_if.last_o      = last_q;
    assign busy_o           = (state_q == RUN) || (state_q == DRAIN);
    assign done_o           = (state_q == DONE);
    assign range_err_o      = range_err_q;
endmodule

// File: tb/tb_poly_sub_stream.sv
// Purpose : directed bench for poly_sub_stream; hand-computed pairs plus frame-level checks.
// Latency : results are scoreboarded in order against bench-computed (a - b) mod 3329.
// Stalls  : out_ready_i is randomly withheld to check hold-stable outputs and input backpressure.
module tb_poly_sub_stream;
    localparam int N = 256;
    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic busy_o;
    logic done_o;
    logic range_err_o;

    poly_sub_stream_if #(.NUM_COEFFS(N)) bus ();

    poly_sub_stream #(.NUM_COEFFS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .range_err_o (range_err_o),
        .s_if        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Pending operand pairs and their expected results, in stream order.
    int a_q[$];
    int b_q[$];
    int er_q[$];
    // Expected index/last, recorded when the pair is actually accepted.
    int ei_q[$];
    bit el_q[$];
    int e_idx = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ref_sub(input int a, input int b);
        if (a >= Q || b >= Q) return 0;
        return (a - b + Q) % Q;
    endfunction

    task automatic push(input int a, input int b, input int r);
        a_q.push_back(a);
        b_q.push_back(b);
        er_q.push_back(r);
    endtask

    task automatic push_rand();
        int a;
        int b;
        a = $urandom_range(Q - 1);
        b = $urandom_range(Q - 1);
        push(a, b, ref_sub(a, b));
    endtask

    // Called at posedge+1; leaves at posedge+1 of the cycle after the start edge.
    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        e_idx   = 0;
    endtask

    // Feed queued pairs and consume results until max_out results have been taken.
    task automatic stream(input int stall_pct, input int max_out);
        int          got = 0;
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic [11:0] p_res = '0;
        logic [7:0]  p_idx = '0;
        logic        p_last = 1'b0;
        while (got < max_out) begin
            if (cyc >= 5000) begin
                chk("timeout", got, max_out);
                break;
            end
            cyc++;
            bus.in_valid_i = (a_q.size() > 0);
            if (a_q.size() > 0) begin
                bus.op1_i = 12'(a_q[0]);
                bus.op2_i = 12'(b_q[0]);
            end
            bus.out_ready_i = ($urandom_range(99) >= stall_pct);
            #1;
            if (done_o) chk("early_done", done_o, 0);
            if (prev_stall) begin
                chk("hold_vld", bus.out_valid_o, 1);
                chk("hold_res", bus.result_o, p_res);
                chk("hold_idx", bus.idx_o, p_idx);
                chk("hold_last", bus.last_o, p_last);
            end
            if (bus.out_valid_o && !bus.out_ready_i) begin
                chk("stall_in_rdy", bus.in_ready_o, 0);
                prev_stall = 1'b1;
                p_res      = bus.result_o;
                p_idx      = bus.idx_o;
                p_last     = bus.last_o;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (ei_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("result", bus.result_o, er_q[0]);
                    chk("idx", bus.idx_o, ei_q[0]);
                    chk("last", bus.last_o, el_q[0]);
                    void'(er_q.pop_front());
                    void'(ei_q.pop_front());
                    void'(el_q.pop_front());
                end
                got++;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                ei_q.push_back(e_idx);
                el_q.push_back(e_idx == N - 1);
                e_idx = (e_idx + 1) % N;
                void'(a_q.pop_front());
                void'(b_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.op1_i       = '0;
        bus.op2_i       = '0;
        bus.out_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_vld", bus.out_valid_o, 0);
        chk("rst_rerr", range_err_o, 0);
        chk("rst_res", bus.result_o, 0);
        chk("rst_idx", bus.idx_o, 0);
        chk("rst_last", bus.last_o, 0);
        chk("rst_in_rdy", bus.in_ready_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // in_valid_i in IDLE is ignored
        bus.in_valid_i = 1'b1;
        bus.op1_i      = 12'd5;
        bus.op2_i      = 12'd3;
        repeat (3) begin
            #1;
            chk("idle_in_rdy", bus.in_ready_o, 0);
            chk("idle_busy", busy_o, 0);
            @(posedge clk);
            #1;
        end
        chk("idle_vld", bus.out_valid_o, 0);
        bus.in_valid_i = 1'b0;

        // Hand-computed pairs at idx 0..4
        do_start();
        chk("run_busy", busy_o, 1);
        chk("run_rerr", range_err_o, 0);
        push(5, 3, 2);
        push(3, 5, 3327);
        push(0, 0, 0);
        push(3328, 0, 3328);
        push(0, 3328, 1);
        stream(0, 5);
        chk("t1_rerr", range_err_o, 0);

        // start_i during RUN: no restart, index keeps counting from 5
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("rerun_busy", busy_o, 1);
        chk("rerun_vld", bus.out_valid_o, 0);

        // Rest of the frame with ~50% stalls; idx 10 carries an out-of-range minuend
        for (int i = 5; i < N; i++) begin
            if (i == 10) push(3329, 7, 0);
            else         push_rand();
        end
        stream(50, N - 5);
        chk("t4_done", done_o, 1);
        chk("t4_rerr_end", range_err_o, 1);
        chk("t4_busy_done", busy_o, 0);
        @(posedge clk);
        #1;
        chk("t4_done_once", done_o, 0);
        chk("t4_rerr_idle", range_err_o, 1);

        // Full random frame at full rate
        do_start();
        chk("t2_rerr_clr", range_err_o, 0);
        for (int i = 0; i < N; i++) push_rand();
        stream(0, N);
        chk("t2_done", done_o, 1);
        chk("t2_busy", busy_o, 0);
        @(posedge clk);
        #1;
        chk("t2_done_once", done_o, 0);
        chk("t2_busy_idle", busy_o, 0);

        // Reset mid-frame with a result pending at idx 100
        do_start();
        for (int i = 0; i <= 100; i++) push_rand();
        stream(0, 100);
        chk("t5_pre_vld", bus.out_valid_o, 1);
        chk("t5_pre_idx", bus.idx_o, 100);
        rst = 1'b1;
        #1;
        chk("t5_rst_vld", bus.out_valid_o, 0);
        chk("t5_rst_busy", busy_o, 0);
        chk("t5_rst_done", done_o, 0);
        chk("t5_rst_idx", bus.idx_o, 0);
        #2;
        rst = 1'b0;
        a_q.delete();
        b_q.delete();
        er_q.delete();
        ei_q.delete();
        el_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("t5_no_done", done_o, 0);
            chk("t5_idle", busy_o, 0);
        end
        do_start();
        push(100, 200, 3229);
        push(7, 7, 0);
        stream(0, 2);
        chk("t5_busy_after", busy_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
